// File: rtl/pipelined_hybrid_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_hybrid_adder_pkg
// Shared constants for the pipelined hybrid adder and its users (ALU,
// multiplier accumulate path): the default geometry and the stage-count helper.
// No ports.
// -----------------------------------------------------------------------------
package pipelined_hybrid_adder_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_BLOCK = 4;

   // One pipeline stage per lookahead slice.
   function automatic int calc_stages(input int width, input int block);
      return width / block;
   endfunction

endpackage

// File: rtl/cla_block.sv
// -----------------------------------------------------------------------------
// cla_block
// Purely combinational BLOCK-bit carry-lookahead slice. Every internal carry is
// a flat sum of generate/propagate products, so the carry does not ripple
// inside the slice.
// Ports:
//   a, b      BLOCK-bit operands (b already conditioned for subtract)
//   cin       carry into bit 0
//   s         BLOCK-bit sum
//   cout      carry out of the top bit
//   c_msb_in  carry into the top bit (used for signed overflow)
// -----------------------------------------------------------------------------
module cla_block #(
   parameter int BLOCK = 4
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             cin,
   output logic [BLOCK-1:0] s,
   output logic             cout,
   output logic             c_msb_in
);

   logic [BLOCK-1:0] g;
   logic [BLOCK-1:0] p;
   logic [BLOCK:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
   // NOTE: always_comb assigns every output before any conditional logic and
   // uses blocking assignments, so no latch can be inferred.
   always_comb begin
      logic pp;
      logic cn;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < BLOCK; i++) begin
         pp = 1'b1;
         cn = 1'b0;
         for (int j = i; j >= 0; j--) begin
            cn = cn | (pp & g[j]);
            pp = pp & p[j];
         end
         c[i+1] = cn | (pp & cin);
      end
   end

   assign s        = p ^ c[BLOCK-1:0];
   assign cout     = c[BLOCK];
   assign c_msb_in = c[BLOCK-1];

endmodule

// File: rtl/pipelined_hybrid_adder.sv
// -----------------------------------------------------------------------------
// pipelined_hybrid_adder
// Pipelined add/subtract unit: STAGES = WIDTH/BLOCK lookahead slices, one per
// pipeline stage, carry rippling stage to stage. Operands travel through a
// delay line so slice k sees its operand bits exactly when stage k-1's carry
// is ready; one WIDTH-bit result completes per cycle at steady state.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready = global enable)
//   a, b, cin, sub       operands; sub=1 computes a-b and ignores cin
//   out_valid/out_ready  result handshake
//   sum, cout, overflow  registered result, carry-out, signed overflow
// -----------------------------------------------------------------------------
module pipelined_hybrid_adder
   import pipelined_hybrid_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int BLOCK = DEF_BLOCK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int STAGES = calc_stages(WIDTH, BLOCK);

   // Per-stage registers: valid, operands delay line, partial result, carry.
   logic             v_q   [STAGES];
   logic [WIDTH-1:0] a_q   [STAGES];
   logic [WIDTH-1:0] b_q   [STAGES];
   logic [WIDTH-1:0] r_q   [STAGES];
   logic             c_q   [STAGES];
   logic             sub_q [STAGES];
   logic             ovf_q;
   logic             en;

   // The whole pipeline advances together; it stalls only when a result sits
   // at the output unaccepted. Bubbles are deliberately not collapsed.
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             v_in;
      logic             c_in;
      logic             sub_in;
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      logic [WIDTH-1:0] r_in;
      logic [BLOCK-1:0] b_eff;
      logic [BLOCK-1:0] s_blk;
      logic             co;
      logic             cm;
      logic [WIDTH-1:0] r_next;

      if (k == 0) begin : g_first
         assign v_in   = in_valid;
         assign a_in   = a;
         assign b_in   = b;
         assign sub_in = sub;
         assign c_in   = sub ? 1'b1 : cin;
         assign r_in   = '0;
      end else begin : g_next
         assign v_in   = v_q[k-1];
         assign a_in   = a_q[k-1];
         assign b_in   = b_q[k-1];
         assign sub_in = sub_q[k-1];
         assign c_in   = c_q[k-1];
         assign r_in   = r_q[k-1];
      end

      // Subtract inverts B one slice at a time, keeping the mux in-stage.
      assign b_eff = sub_in ? ~b_in[k*BLOCK +: BLOCK] : b_in[k*BLOCK +: BLOCK];

      cla_block #(.BLOCK(BLOCK)) u_cla (
         .a        (a_in[k*BLOCK +: BLOCK]),
         .b        (b_eff),
         .cin      (c_in),
         .s        (s_blk),
         .cout     (co),
         .c_msb_in (cm)
      );

      always_comb begin
         r_next                   = r_in;
         r_next[k*BLOCK +: BLOCK] = s_blk;
      end

      // NOTE: every pipeline data register is reset, not just the valid bits,
      // so the outputs read 0 straight after reset rather than stale data.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q[k]   <= 1'b0;
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            r_q[k]   <= '0;
            c_q[k]   <= 1'b0;
            sub_q[k] <= 1'b0;
         end else if (en) begin
            v_q[k] <= v_in;
            // Bubbles leave the data registers untouched so outputs hold.
            if (v_in) begin
               a_q[k]   <= a_in;
               b_q[k]   <= b_in;
               r_q[k]   <= r_next;
               c_q[k]   <= co;
               sub_q[k] <= sub_in;
            end
         end
      end

      if (k == STAGES-1) begin : g_last
         // Signed overflow: carry into MSB differs from carry out of MSB.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else if (en && v_in) begin
               ovf_q <= co ^ cm;
            end
         end
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign sum       = r_q[STAGES-1];
   assign cout      = c_q[STAGES-1];
   assign overflow  = ovf_q;

endmodule
